// File: rtl/inst_fetch_pkg.sv
// Shared instruction-bus widths and pipeline control level constants for the fetch stage.
package inst_fetch_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstDataW = 32;

  localparam int unsigned StallW       = 6;
  localparam int unsigned StallIfIdBit = 1;

  localparam logic ChipEnable = 1'b1;
  localparam logic StallHold  = 1'b1;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding bus read per instruction, held for IF/ID until it is taken.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = InstAddrW,
  parameter int unsigned DATA_W = InstDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic [StallW-1:0] stall,
  input  logic              flush_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ack_i,
  input  logic [DATA_W-1:0] inst_rdata_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              stallreq_o
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrop} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;

  logic fetch_en;
  logic if_id_hold;
  logic unused_stall;

  assign fetch_en     = (ce_i == ChipEnable);
  assign if_id_hold   = (stall[StallIfIdBit] == StallHold);
  assign unused_stall = ^{stall[StallW-1:StallIfIdBit+1], stall[StallIfIdBit-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (fetch_en && !flush_i) state_d = StReq;
      StReq: begin
        if (inst_ack_i) state_d = flush_i ? StIdle : StHold;
        else if (flush_i) state_d = StDrop;
      end
      // The bus cannot cancel a read, so a flushed fetch waits out its ack here.
      StDrop: if (inst_ack_i) state_d = StIdle;
      StHold: if (flush_i || !if_id_hold) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    pc_d   = pc_q;
    inst_d = inst_q;
    unique case (state_q)
      StIdle: if (fetch_en && !flush_i) addr_d = pc_i;
      StReq: begin
        if (inst_ack_i && !flush_i) begin
          inst_d = inst_rdata_i;
          pc_d   = addr_q;
        end
      end
      // Flushing a held instruction turns it into a NOP for IF/ID.
      StHold: if (flush_i) inst_d = '0;
      default: ;
    endcase
  end

  always_comb begin
    inst_req_o   = 1'b0;
    inst_valid_o = 1'b0;
    stallreq_o   = 1'b0;
    unique case (state_q)
      StIdle: stallreq_o = fetch_en && !flush_i;
      StReq: begin
        inst_req_o = 1'b1;
        stallreq_o = !inst_ack_i;
      end
      StDrop: begin
        inst_req_o = 1'b1;
        stallreq_o = 1'b1;
      end
      StHold: inst_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign inst_addr_o = addr_q;
  assign inst_o      = inst_q;
  assign inst_pc_o   = pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [5:0]  stall;
  logic        flush_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i;
  logic [31:0] inst_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  inst_fetch #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .ce_i        (ce_i),
    .stall       (stall),
    .flush_i     (flush_i),
    .inst_req_o  (inst_req_o),
    .inst_addr_o (inst_addr_o),
    .inst_ack_i  (inst_ack_i),
    .inst_rdata_i(inst_rdata_i),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o),
    .inst_valid_o(inst_valid_o),
    .stallreq_o  (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an outstanding bus read (wanted or abandoned) and a held result.
  logic        m_busy;
  logic        m_keep;
  logic        m_have;
  logic [31:0] m_addr;
  logic [31:0] m_inst;
  logic [31:0] m_pc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_keep <= 1'b0;
      m_have <= 1'b0;
      m_addr <= '0;
      m_inst <= '0;
      m_pc   <= '0;
    end else if (m_have) begin
      if (flush_i) begin
        m_have <= 1'b0;
        m_inst <= '0;
      end else if (!stall[1]) begin
        m_have <= 1'b0;
      end
    end else if (m_busy) begin
      if (inst_ack_i) begin
        m_busy <= 1'b0;
        if (m_keep && !flush_i) begin
          m_have <= 1'b1;
          m_inst <= inst_rdata_i;
          m_pc   <= m_addr;
        end
      end else if (flush_i) begin
        m_keep <= 1'b0;
      end
    end else if (ce_i && !flush_i) begin
      m_busy <= 1'b1;
      m_keep <= 1'b1;
      m_addr <= pc_i;
    end
  end

  always @(negedge clk) begin
    logic exp_stallreq;
    exp_stallreq = (!m_busy && !m_have && ce_i && !flush_i)
                 || (m_busy && m_keep && !inst_ack_i)
                 || (m_busy && !m_keep);
    chk("cmp_req",      32'(inst_req_o),   32'(m_busy));
    chk("cmp_addr",     inst_addr_o,       m_addr);
    chk("cmp_valid",    32'(inst_valid_o), 32'(m_have));
    chk("cmp_inst",     inst_o,            m_inst);
    chk("cmp_pc",       inst_pc_o,         m_pc);
    chk("cmp_stallreq", 32'(stallreq_o),   32'(exp_stallreq));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    ce_i         = 1'b0;
    pc_i         = '0;
    stall        = '0;
    flush_i      = 1'b0;
    inst_ack_i   = 1'b0;
    inst_rdata_i = '0;
    repeat (3) tick();
    #1;
    chk("rst_req",   32'(inst_req_o),   0);
    chk("rst_addr",  inst_addr_o,       0);
    chk("rst_inst",  inst_o,            0);
    chk("rst_pc",    inst_pc_o,         0);
    chk("rst_valid", 32'(inst_valid_o), 0);

    // Boot fetch with ack in the first request cycle.
    rst  = 1'b1;
    ce_i = 1'b1;
    pc_i = 32'hBFC0_0000;
    #1;
    chk("boot_idle_stallreq", 32'(stallreq_o), 1);
    chk("boot_idle_req",      32'(inst_req_o), 0);
    tick();
    ce_i         = 1'b0;
    inst_ack_i   = 1'b1;
    inst_rdata_i = 32'h3C01_0001;
    #1;
    chk("boot_req",      32'(inst_req_o),   1);
    chk("boot_addr",     inst_addr_o,       32'hBFC0_0000);
    chk("boot_valid0",   32'(inst_valid_o), 0);
    chk("boot_stallreq", 32'(stallreq_o),   0);
    tick();
    inst_ack_i = 1'b0;
    #1;
    chk("boot_valid", 32'(inst_valid_o), 1);
    chk("boot_inst",  inst_o,            32'h3C01_0001);
    chk("boot_pc",    inst_pc_o,         32'hBFC0_0000);
    tick();
    #1;
    chk("boot_done_valid", 32'(inst_valid_o), 0);

    // Ack delayed by three cycles, then a five-cycle IF/ID stall.
    ce_i = 1'b1;
    pc_i = 32'h0000_1234;
    tick();
    ce_i = 1'b0;
    pc_i = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        inst_ack_i   = 1'b1;
        inst_rdata_i = 32'hA5A5_0F0F;
      end
      #1;
      chk("slow_req",  32'(inst_req_o), 1);
      chk("slow_addr", inst_addr_o,     32'h0000_1234);
      if (i < 3) chk("slow_stallreq", 32'(stallreq_o), 1);
      tick();
    end
    inst_ack_i = 1'b0;
    stall      = 6'b00_0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_valid",    32'(inst_valid_o), 1);
      chk("hold_inst",     inst_o,            32'hA5A5_0F0F);
      chk("hold_pc",       inst_pc_o,         32'h0000_1234);
      chk("hold_stallreq", 32'(stallreq_o),   0);
      tick();
    end
    stall = '0;
    #1;
    chk("release_valid", 32'(inst_valid_o), 1);
    tick();
    #1;
    chk("released_valid", 32'(inst_valid_o), 0);

    // Flush before ack: the late data must never surface.
    ce_i = 1'b1;
    pc_i = 32'h0000_2000;
    tick();
    ce_i    = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("drop_enter_stallreq", 32'(stallreq_o), 1);
    tick();
    flush_i = 1'b0;
    #1;
    chk("drop_req",      32'(inst_req_o),   1);
    chk("drop_addr",     inst_addr_o,       32'h0000_2000);
    chk("drop_stallreq", 32'(stallreq_o),   1);
    chk("drop_valid",    32'(inst_valid_o), 0);
    tick();
    inst_ack_i   = 1'b1;
    inst_rdata_i = 32'hFFFF_FFFF;
    #1;
    chk("drop_ack_req", 32'(inst_req_o), 1);
    tick();
    inst_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drop_idle_req",   32'(inst_req_o),   0);
      chk("drop_idle_valid", 32'(inst_valid_o), 0);
      chk("drop_idle_inst",  inst_o,            32'hA5A5_0F0F);
      tick();
    end

    // Flush while holding an instruction turns it into a NOP.
    ce_i = 1'b1;
    pc_i = 32'h0000_3000;
    tick();
    ce_i         = 1'b0;
    inst_ack_i   = 1'b1;
    inst_rdata_i = 32'h1357_9BDF;
    tick();
    inst_ack_i = 1'b0;
    stall      = 6'b00_0010;
    flush_i    = 1'b1;
    #1;
    chk("nop_pre_inst", inst_o, 32'h1357_9BDF);
    tick();
    flush_i = 1'b0;
    stall   = '0;
    #1;
    chk("nop_inst",  inst_o,            32'h0000_0000);
    chk("nop_valid", 32'(inst_valid_o), 0);
    chk("nop_pc",    inst_pc_o,         32'h0000_3000);

    // Reset in the middle of a request, then a stray ack after release.
    tick();
    ce_i = 1'b1;
    pc_i = 32'h0000_4000;
    tick();
    ce_i = 1'b0;
    #1;
    chk("mid_req", 32'(inst_req_o), 1);
    rst = 1'b0;
    #1;
    chk("async_req",  32'(inst_req_o), 0);
    chk("async_addr", inst_addr_o,     0);
    chk("async_inst", inst_o,          0);
    tick();
    rst          = 1'b1;
    inst_ack_i   = 1'b1;
    inst_rdata_i = 32'hDEAD_BEEF;
    tick();
    inst_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stray_valid", 32'(inst_valid_o), 0);
      chk("stray_req",   32'(inst_req_o),   0);
      chk("stray_inst",  inst_o,            0);
      tick();
    end

    // Randomized traffic, checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      ce_i         = ($urandom_range(0, 3) != 0);
      pc_i         = $urandom;
      stall        = 6'($urandom);
      flush_i      = ($urandom_range(0, 7) == 0);
      inst_ack_i   = ($urandom_range(0, 2) == 0);
      inst_rdata_i = $urandom;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst = 1'b0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
